// File: rtl/regarb_pkg.sv
// Shared defaults and grant encodings for the register-file write arbiter.
package regarb_pkg;

    localparam int DEFAULT_BITS_DATA = 32;
    localparam int DEFAULT_BITS_ADDR = 3;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grantSelT;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: a one-hot grant from the valids, and priority
// that rotates only when a transfer actually happens.
module rr_arbiter2
    import regarb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       transfer,
    output logic [1:0] grant
);

    grantSelT lastGrant;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = (lastGrant == GRANT_REQ1) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= GRANT_REQ1;
        end else if (transfer) begin
            lastGrant <= grant[1] ? GRANT_REQ1 : GRANT_REQ0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single writer of the register array: round-robin over ALU/load writebacks, registered write port, busy scoreboard.
// Optional build macro REGARB_R0_ZERO_EN makes R0 hardwired zero.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter  int BITS_DATA = DEFAULT_BITS_DATA,
    parameter  int BITS_ADDR = DEFAULT_BITS_ADDR,
    localparam int NREGS     = 2 ** BITS_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wreq0_valid,
    input  logic [BITS_ADDR-1:0] wreq0_addr,
    input  logic [BITS_DATA-1:0] wreq0_data,
    output logic                 wreq0_ready,
    input  logic                 wreq1_valid,
    input  logic [BITS_ADDR-1:0] wreq1_addr,
    input  logic [BITS_DATA-1:0] wreq1_data,
    output logic                 wreq1_ready,
    input  logic                 rsv_valid,
    input  logic [BITS_ADDR-1:0] rsv_addr,
    input  logic [BITS_ADDR-1:0] rd1_addr,
    input  logic [BITS_ADDR-1:0] rd2_addr,
    output logic                 rd1_stall,
    output logic                 rd2_stall,
    output logic                 rf_we,
    output logic [BITS_ADDR-1:0] rf_waddr,
    output logic [BITS_DATA-1:0] rf_wdata,
    output logic [NREGS-1:0]     busy
);

    logic [1:0]           grant;
    logic                 transfer;
    logic [BITS_ADDR-1:0] selAddr;
    logic [BITS_DATA-1:0] selData;
    logic                 writeEn;
    logic [NREGS-1:0]     busyNext;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    ({wreq1_valid, wreq0_valid}),
        .transfer (transfer),
        .grant    (grant)
    );

    assign wreq0_ready = grant[0];
    assign wreq1_ready = grant[1];
    assign transfer    = |(grant & {wreq1_valid, wreq0_valid});
    assign selAddr     = grant[1] ? wreq1_addr : wreq0_addr;
    assign selData     = grant[1] ? wreq1_data : wreq0_data;

`ifdef REGARB_R0_ZERO_EN
    // R0 writes still handshake so the requester can retire them; they just never reach the array.
    assign writeEn = transfer && (selAddr != '0);
`else
    assign writeEn = transfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= writeEn;
            if (writeEn) begin
                rf_waddr <= selAddr;
                rf_wdata <= selData;
            end
        end
    end

    // Reservation is applied after the clear so a same-cycle set on the written register wins.
    always_comb begin
        busyNext = busy;
        if (rf_we) begin
            busyNext[rf_waddr] = 1'b0;
        end
        if (rsv_valid) begin
            busyNext[rsv_addr] = 1'b1;
        end
`ifdef REGARB_R0_ZERO_EN
        busyNext[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign rd1_stall = busy[rd1_addr];
    assign rd2_stall = busy[rd2_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model. Honours REGARB_R0_ZERO_EN when defined.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wreq0_valid = 1'b0;
    logic [2:0]  wreq0_addr = '0;
    logic [31:0] wreq0_data = '0;
    logic        wreq0_ready;
    logic        wreq1_valid = 1'b0;
    logic [2:0]  wreq1_addr = '0;
    logic [31:0] wreq1_data = '0;
    logic        wreq1_ready;
    logic        rsv_valid = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic [2:0]  rd1_addr = '0;
    logic [2:0]  rd2_addr = '0;
    logic        rd1_stall;
    logic        rd2_stall;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  busy;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wreq0_valid (wreq0_valid),
        .wreq0_addr  (wreq0_addr),
        .wreq0_data  (wreq0_data),
        .wreq0_ready (wreq0_ready),
        .wreq1_valid (wreq1_valid),
        .wreq1_addr  (wreq1_addr),
        .wreq1_data  (wreq1_data),
        .wreq1_ready (wreq1_ready),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .rd1_addr    (rd1_addr),
        .rd2_addr    (rd2_addr),
        .rd1_stall   (rd1_stall),
        .rd2_stall   (rd2_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wreq0_valid = 1'b0; wreq0_addr = '0; wreq0_data = '0;
        wreq1_valid = 1'b0; wreq1_addr = '0; wreq1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; rd1_addr = '0; rd2_addr = '0;
    endtask

    task automatic resetDut();
        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Behavioural model: who wins, what lands in the array one cycle later, which registers are pending.
    bit          modelOn = 1'b0;
    bit          r0Zero;
    int          mLastWinner;
    bit          mBusy[8];
    bit          mWe;
    logic [2:0]  mWaddr;
    logic [31:0] mWdata;
    bit          acc0, acc1;

    function automatic int winner(input bit v0, input bit v1);
        if (v0 && v1) return (mLastWinner == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        mLastWinner = 1;
        foreach (mBusy[i]) mBusy[i] = 1'b0;
        mWe = 1'b0; mWaddr = '0; mWdata = '0;
        acc0 = 1'b0; acc1 = 1'b0;
    endtask

    always @(posedge clk) begin
        if (modelOn) begin
            int w;
            logic [2:0]  a;
            logic [31:0] d;
            w = winner(wreq0_valid, wreq1_valid);
            acc0 = (w == 0);
            acc1 = (w == 1);
            if (mWe) mBusy[mWaddr] = 1'b0;
            if (rsv_valid && !(r0Zero && rsv_addr == 0)) mBusy[rsv_addr] = 1'b1;
            a = (w == 1) ? wreq1_addr : wreq0_addr;
            d = (w == 1) ? wreq1_data : wreq0_data;
            mWe = (w >= 0) && !(r0Zero && a == 0);
            if (mWe) begin
                mWaddr = a;
                mWdata = d;
            end
            if (w >= 0) mLastWinner = w;
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            int w;
            logic [7:0] expBusy;
            w = winner(wreq0_valid, wreq1_valid);
            foreach (mBusy[i]) expBusy[i] = mBusy[i];
            check("rnd_ready0", {31'b0, wreq0_ready}, {31'b0, w == 0});
            check("rnd_ready1", {31'b0, wreq1_ready}, {31'b0, w == 1});
            check("rnd_rf_we", {31'b0, rf_we}, {31'b0, mWe});
            if (mWe) begin
                check("rnd_rf_waddr", {29'b0, rf_waddr}, {29'b0, mWaddr});
                check("rnd_rf_wdata", rf_wdata, mWdata);
            end
            check("rnd_busy", {24'b0, busy}, {24'b0, expBusy});
            check("rnd_rd1_stall", {31'b0, rd1_stall}, {31'b0, mBusy[rd1_addr]});
            check("rnd_rd2_stall", {31'b0, rd2_stall}, {31'b0, mBusy[rd2_addr]});
        end
    end

    initial begin
        logic [2:0] expA [4];
        expA = '{3'd1, 3'd2, 3'd4, 3'd6};
`ifdef REGARB_R0_ZERO_EN
        r0Zero = 1'b1;
`else
        r0Zero = 1'b0;
`endif

        // Reset state and a single ALU write.
        resetDut();
        #1;
        check("reset_rf_we", {31'b0, rf_we}, 32'd0);
        check("reset_rf_waddr", {29'b0, rf_waddr}, 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        check("reset_busy", {24'b0, busy}, 32'd0);
        wreq0_valid = 1'b1; wreq0_addr = 3'd3; wreq0_data = 32'hDEADBEEF;
        #1;
        check("t1_ready0", {31'b0, wreq0_ready}, 32'd1);
        check("t1_ready1", {31'b0, wreq1_ready}, 32'd0);
        step();
        wreq0_valid = 1'b0;
        check("t1_rf_we", {31'b0, rf_we}, 32'd1);
        check("t1_rf_waddr", {29'b0, rf_waddr}, 32'd3);
        check("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        check("t1_rf_we_idle", {31'b0, rf_we}, 32'd0);

        // Both requesters contend for four cycles: req0 wins the first tie after reset.
        resetDut();
        wreq0_valid = 1'b1; wreq0_addr = 3'd1; wreq0_data = 32'h11;
        wreq1_valid = 1'b1; wreq1_addr = 3'd2; wreq1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_ready0", {31'b0, wreq0_ready}, {31'b0, k % 2 == 0});
            check("t2_ready1", {31'b0, wreq1_ready}, {31'b0, k % 2 == 1});
            step();
            check("t2_rf_we", {31'b0, rf_we}, 32'd1);
            check("t2_rf_waddr", {29'b0, rf_waddr}, {29'b0, expA[k]});
            if (k % 2 == 0) begin
                wreq0_addr = 3'd4; wreq0_data = 32'h44;
            end else begin
                wreq1_addr = 3'd6; wreq1_data = 32'h66;
            end
        end
        idleInputs();
        step();
        check("t2_rf_we_end", {31'b0, rf_we}, 32'd0);

        // Reserve R5, observe stall, then retire it with a write.
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        step();
        rsv_valid = 1'b0; rd1_addr = 3'd5;
        #1;
        check("t3_busy5", {31'b0, busy[5]}, 32'd1);
        check("t3_rd1_stall", {31'b0, rd1_stall}, 32'd1);
        wreq0_valid = 1'b1; wreq0_addr = 3'd5; wreq0_data = 32'h55;
        step();
        wreq0_valid = 1'b0;
        check("t3_rf_we", {31'b0, rf_we}, 32'd1);
        check("t3_stall_during_write", {31'b0, rd1_stall}, 32'd1);
        step();
        check("t3_busy5_cleared", {31'b0, busy[5]}, 32'd0);
        check("t3_rd1_stall_cleared", {31'b0, rd1_stall}, 32'd0);

        // Reserve R2 again in the same cycle its write lands: the reservation survives.
        rsv_valid = 1'b1; rsv_addr = 3'd2;
        step();
        rsv_valid = 1'b0;
        wreq1_valid = 1'b1; wreq1_addr = 3'd2; wreq1_data = 32'h2222;
        step();
        wreq1_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 3'd2;
        check("t4_rf_we", {31'b0, rf_we}, 32'd1);
        step();
        rsv_valid = 1'b0;
        check("t4_busy2_kept", {31'b0, busy[2]}, 32'd1);

        // Reset lands between a transfer and its write: the write is dropped.
        wreq0_valid = 1'b1; wreq0_addr = 3'd4; wreq0_data = 32'h4444;
        step();
        wreq0_valid = 1'b0;
        check("t5_rf_we_pre", {31'b0, rf_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rf_we_async", {31'b0, rf_we}, 32'd0);
        check("t5_busy_async", {24'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_no_write_after", {31'b0, rf_we}, 32'd0);
        end

        // Load unit writes R0 while R0 is reserved.
        wreq1_valid = 1'b1; wreq1_addr = 3'd0; wreq1_data = 32'h12345678;
        rsv_valid = 1'b1; rsv_addr = 3'd0;
        #1;
        check("t6_ready1", {31'b0, wreq1_ready}, 32'd1);
        step();
        wreq1_valid = 1'b0; rsv_valid = 1'b0;
`ifdef REGARB_R0_ZERO_EN
        check("t6_rf_we", {31'b0, rf_we}, 32'd0);
        check("t6_busy0", {31'b0, busy[0]}, 32'd0);
`else
        check("t6_rf_we", {31'b0, rf_we}, 32'd1);
        check("t6_rf_waddr", {29'b0, rf_waddr}, 32'd0);
        check("t6_busy0", {31'b0, busy[0]}, 32'd1);
`endif

        // Randomized traffic against the model; requesters hold their request until accepted.
        resetDut();
        modelReset();
        modelOn = 1'b1;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (acc0) wreq0_valid = 1'b0;
            if (acc1) wreq1_valid = 1'b0;
            if (!wreq0_valid && ($urandom_range(0, 2) != 0)) begin
                wreq0_valid = 1'b1;
                wreq0_addr = 3'($urandom_range(0, 7));
                wreq0_data = $urandom;
            end
            if (!wreq1_valid && ($urandom_range(0, 2) != 0)) begin
                wreq1_valid = 1'b1;
                wreq1_addr = 3'($urandom_range(0, 7));
                wreq1_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr = 3'($urandom_range(0, 7));
            rd1_addr = 3'($urandom_range(0, 7));
            rd2_addr = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        modelOn = 1'b0;
        idleInputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
